// File: rtl/qif_pkg.sv
// Shared constants, FSM state type and sizing helper for the QIF neuron array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qif_pkg;

  localparam int QIF_WIDTH        = 8;
  localparam int QIF_N_NEURONS    = 4;
  localparam int QIF_V_REST       = 32;
  localparam int QIF_V_TH         = 200;
  localparam int QIF_V_RESET      = 16;
  localparam int QIF_SQ_SHIFT     = 5;
  localparam int QIF_REFRAC_STEPS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qif_neuron_array_if.sv
// Step request / current / spike / readback bundle of the QIF neuron array.
// Latency: n/a (wires only).
// Backpressure: step is only taken while the array is idle; busy tells the driver.
interface qif_neuron_array_if #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int IW        = 2
);
  logic                       step;
  logic [N_NEURONS*WIDTH-1:0] i_cur;
  logic                       busy;
  logic                       done;
  logic [N_NEURONS-1:0]       spikes;
  logic [IW-1:0]              rd_sel;
  logic [WIDTH-1:0]           rd_v;

  modport master (output step, i_cur, rd_sel, input busy, done, spikes, rd_v);
  modport slave  (input step, i_cur, rd_sel, output busy, done, spikes, rd_v);
endinterface

// File: rtl/qif_update.sv
// Shared combinational QIF update: v_next = clamp(v + (v-V_REST)^2>>SQ_SHIFT + i), spike on threshold.
// Latency: zero (pure combinational).
// Backpressure: none.
module qif_update import qif_pkg::*; #(
  parameter int WIDTH    = QIF_WIDTH,
  parameter int V_REST   = QIF_V_REST,
  parameter int V_TH     = QIF_V_TH,
  parameter int V_RESET  = QIF_V_RESET,
  parameter int SQ_SHIFT = QIF_SQ_SHIFT
) (
  input  logic [WIDTH-1:0]        v,
  input  logic signed [WIDTH-1:0] i,
  input  logic                    refr_act,
  output logic [WIDTH-1:0]        v_next,
  output logic                    spike
);
  // Wide enough that the square and the three-way sum never overflow.
  localparam int SW   = 2*WIDTH + 4;
  localparam int MAXV = (1 << WIDTH) - 1;

  logic signed [SW-1:0] d, prod, q, s;
  logic [WIDTH-1:0]     v_clamp;

  // Full-precision integrate, clamp to the unsigned range, then apply threshold/refractory.
  always_comb begin
    d       = $signed({{(SW-WIDTH){1'b0}}, v}) - SW'(V_REST);
    prod    = d * d;
    q       = prod >>> SQ_SHIFT;
    s       = $signed({{(SW-WIDTH){1'b0}}, v}) + q + $signed({{(SW-WIDTH){i[WIDTH-1]}}, i});
    v_clamp = s[WIDTH-1:0];
    if (s < 0)
      v_clamp = '0;
    else if (s > SW'(MAXV))
      v_clamp = '1;
    v_next = v_clamp;
    spike  = 1'b0;
    if (refr_act) begin
      v_next = WIDTH'(V_RESET);
    end else if (v_clamp >= WIDTH'(V_TH)) begin
      v_next = WIDTH'(V_RESET);
      spike  = 1'b1;
    end
  end
endmodule

// File: rtl/qif_neuron_array.sv
// N QIF neurons on one time-multiplexed datapath; optional refractory via QIF_REFRACTORY_EN.
// Latency: step at cycle t -> neuron k written end of t+1+k, done pulse at t+N+1.
// Backpressure: step ignored while busy (no queueing); next step accepted from t+N+2.
module qif_neuron_array import qif_pkg::*; #(
  parameter int WIDTH        = QIF_WIDTH,
  parameter int N_NEURONS    = QIF_N_NEURONS,
  parameter int V_REST       = QIF_V_REST,
  parameter int V_TH         = QIF_V_TH,
  parameter int V_RESET      = QIF_V_RESET,
  parameter int SQ_SHIFT     = QIF_SQ_SHIFT,
  parameter int REFRAC_STEPS = QIF_REFRAC_STEPS
) (
  input logic              clk,
  input logic              rst,
  qif_neuron_array_if.slave bus
);
  localparam int IW = idx_w(N_NEURONS);
  localparam int RW = idx_w(REFRAC_STEPS + 1);

  state_t                     state, state_nxt;
  logic [IW-1:0]              idx;
  logic [WIDTH-1:0]           v [N_NEURONS];
  logic [N_NEURONS*WIDTH-1:0] cur_sh;
  logic [N_NEURONS-1:0]       spk_sh;
  logic [N_NEURONS-1:0]       spikes_q;
  logic [WIDTH-1:0]           v_next;
  logic                       spk_next;
  logic                       refr_act;
  logic                       last;
  logic                       busy_c, done_c;

  assign last = (idx == IW'(N_NEURONS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE:    if (bus.step) state_nxt = UPDATE;
      UPDATE:  begin busy_c = 1'b1; if (last) state_nxt = DONE; end
      DONE:    begin busy_c = 1'b1; done_c = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.spikes = spikes_q;
  assign bus.rd_v   = (int'(bus.rd_sel) < N_NEURONS) ? v[bus.rd_sel] : '0;

  qif_update #(
    .WIDTH(WIDTH), .V_REST(V_REST), .V_TH(V_TH), .V_RESET(V_RESET), .SQ_SHIFT(SQ_SHIFT)
  ) u_update (
    .v        (v[idx]),
    .i        (cur_sh[int'(idx)*WIDTH +: WIDTH]),
    .refr_act (refr_act),
    .v_next   (v_next),
    .spike    (spk_next)
  );

  // Shadow capture on accept, one membrane write per UPDATE cycle, spike publish in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) v[k] <= WIDTH'(V_REST);
      cur_sh   <= '0;
      spk_sh   <= '0;
      spikes_q <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.step) begin
          cur_sh <= bus.i_cur;
          spk_sh <= '0;
          idx    <= '0;
        end
        UPDATE: begin
          v[idx]      <= v_next;
          spk_sh[idx] <= spk_next;
          idx         <= idx + 1'b1;
        end
        DONE:    spikes_q <= spk_sh;
        default: ;
      endcase
    end
  end

`ifdef QIF_REFRACTORY_EN
  logic [RW-1:0] refr [N_NEURONS];

  assign refr_act = (refr[idx] != '0);

  // Per-neuron refractory countdown, armed by a spike and consumed one step at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) refr[k] <= '0;
    end else if (state == UPDATE) begin
      if (refr[idx] != '0)
        refr[idx] <= refr[idx] - 1'b1;
      else if (spk_next)
        refr[idx] <= RW'(REFRAC_STEPS);
    end
  end
`else
  logic unused_refr;
  assign refr_act    = 1'b0;
  assign unused_refr = ^RW'(REFRAC_STEPS);
`endif

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array: vector table, corner sequences, random vs model.
// Latency: checks the done pulse lands N+1 cycles after an accepted step.
// Backpressure: checks that step is ignored while busy.
module tb_qif_neuron_array;
  import qif_pkg::*;

  localparam int W  = QIF_WIDTH;
  localparam int N  = QIF_N_NEURONS;
  localparam int IW = idx_w(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qif_neuron_array_if #(.WIDTH(W), .N_NEURONS(N), .IW(IW)) bus ();
  qif_neuron_array dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference state: membrane, last spike flag, refractory steps left.
  int m_v [N];
  int m_spk [N];
  int m_ref [N];

  typedef struct packed {
    logic         rst_before;
    logic [N*W-1:0] cur;
    logic [N*W-1:0] exp_v;
    logic [N-1:0]   exp_spk;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k] = QIF_V_REST; m_spk[k] = 0; m_ref[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic [N*W-1:0] cur);
    for (int k = 0; k < N; k++) begin
      int i, d, q, s;
      logic signed [W-1:0] c;
      c = cur[k*W +: W];
      i = int'(c);
      if (m_ref[k] > 0) begin
        m_ref[k]--; m_v[k] = QIF_V_RESET; m_spk[k] = 0;
      end else begin
        d = m_v[k] - QIF_V_REST;
        q = (d * d) / (1 << QIF_SQ_SHIFT);
        s = m_v[k] + q + i;
        if (s < 0) s = 0;
        if (s > (1 << W) - 1) s = (1 << W) - 1;
        if (s >= QIF_V_TH) begin
          m_v[k] = QIF_V_RESET; m_spk[k] = 1;
`ifdef QIF_REFRACTORY_EN
          m_ref[k] = QIF_REFRAC_STEPS;
`endif
        end else begin
          m_v[k] = s; m_spk[k] = 0;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // One accepted step; the inputs are scrambled right after acceptance.
  task automatic run_step(input logic [N*W-1:0] cur, input string tag);
    int lat = 0;
    int busy_low = 0;
    @(negedge clk); bus.step = 1'b1; bus.i_cur = cur;
    @(posedge clk); #1; bus.step = 1'b0; bus.i_cur = (N*W)'($urandom);
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (!bus.busy) busy_low++;
      if (bus.done) break;
    end
    check({tag, " latency"}, lat, N + 1);
    check({tag, " busy during sweep"}, busy_low, 0);
    @(negedge clk);
    check({tag, " busy after"}, bus.busy, 0);
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < N; k++) begin
      bus.rd_sel = IW'(k); #1;
      check($sformatf("%s v%0d", tag, k), bus.rd_v, m_v[k]);
      check($sformatf("%s spk%0d", tag, k), bus.spikes[k], m_spk[k]);
    end
  endtask

  initial begin
    logic [N*W-1:0] cur;
    int ndone;

    tbl[0] = '{1'b1, {4{8'd10}}, {4{8'd42}}, 4'b0000};
    tbl[1] = '{1'b0, {4{8'd10}}, {4{8'd55}}, 4'b0000};
    tbl[2] = '{1'b1, {8'd0, 8'd0, 8'h9C, 8'h7F}, {8'd32, 8'd32, 8'd0, 8'd159}, 4'b0000};
    tbl[3] = '{1'b0, {8'd0, 8'd0, 8'd0, 8'h7F}, {8'd32, 8'd32, 8'd32, 8'd16}, 4'b0001};

    // Reset state.
    rst = 1'b1; bus.step = 1'b0; bus.i_cur = '0; bus.rd_sel = '0;
    #2;
    for (int k = 0; k < N; k++) begin
      bus.rd_sel = IW'(k); #1;
      check($sformatf("reset v%0d", k), bus.rd_v, 32);
    end
    check("reset spikes", bus.spikes, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    @(negedge clk); rst = 1'b0;
    model_reset();

    // Vector table.
    for (int t = 0; t < 4; t++) begin
      if (tbl[t].rst_before) do_reset();
      model_step(tbl[t].cur);
      run_step(tbl[t].cur, $sformatf("tbl%0d", t));
      for (int k = 0; k < N; k++) begin
        bus.rd_sel = IW'(k); #1;
        check($sformatf("tbl%0d v%0d", t, k), bus.rd_v, tbl[t].exp_v[k*W +: W]);
      end
      check($sformatf("tbl%0d spikes", t), bus.spikes, tbl[t].exp_spk);
    end

    // Reset during the cycle neuron 2 is being written.
    cur = {4{8'd10}};
    @(negedge clk); bus.step = 1'b1; bus.i_cur = cur;
    @(posedge clk); #1; bus.step = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1; #1;
    for (int k = 0; k < N; k++) begin
      bus.rd_sel = IW'(k); #1;
      check($sformatf("midrst v%0d", k), bus.rd_v, 32);
    end
    check("midrst spikes", bus.spikes, 0);
    check("midrst busy", bus.busy, 0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (bus.done) ndone++;
    end
    check("midrst no done", ndone, 0);
    model_step(cur);
    run_step(cur, "postrst");
    check_model("postrst");

    // step held high for 10 cycles: accepts at cycles 0 and 6 only.
    cur = {8'd3, 8'hF0, 8'd20, 8'd50};
    ndone = 0;
    @(negedge clk); bus.step = 1'b1; bus.i_cur = cur;
    for (int c = 0; c < 16; c++) begin
      int cyc;
      @(posedge clk); @(negedge clk);
      cyc = c + 1;
      check($sformatf("held busy c%0d", cyc), bus.busy,
            ((cyc >= 1 && cyc <= 5) || (cyc >= 7 && cyc <= 11)) ? 1 : 0);
      check($sformatf("held done c%0d", cyc), bus.done, (cyc == 5 || cyc == 11) ? 1 : 0);
      if (bus.done) ndone++;
      if (c == 9) bus.step = 1'b0;
    end
    check("held done count", ndone, 2);
    model_step(cur);
    model_step(cur);
    check_model("held");

    // Random currents against the reference model.
    for (int r = 0; r < 25; r++) begin
      cur = (N*W)'($urandom);
      model_step(cur);
      run_step(cur, $sformatf("rnd%0d", r));
      check_model($sformatf("rnd%0d", r));
    end

`ifdef QIF_REFRACTORY_EN
    begin
      int exp_v0 [5] = '{159, 16, 16, 16, 151};
      int exp_s0 [5] = '{0, 1, 0, 0, 0};
      do_reset();
      cur = {8'd0, 8'd0, 8'd0, 8'h7F};
      for (int s = 0; s < 5; s++) begin
        run_step(cur, $sformatf("refr%0d", s));
        bus.rd_sel = '0; #1;
        check($sformatf("refr%0d v0", s), bus.rd_v, exp_v0[s]);
        check($sformatf("refr%0d spk0", s), bus.spikes[0], exp_s0[s]);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
